// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Arbitrates an instruction-fetch port and a load/store data port onto a
//   single-port memory. Data requests have priority over fetches. Each access
//   holds mem_* stable until mem_ack or until a wait watchdog expires. A
//   watchdog abort completes the access with zero read data and sets a sticky
//   err flag.
//
//   Build option: define MEM_ARB_FAIRNESS_EN to enable a starve counter that
//   forces a fetch grant after STARVE_LIMIT consecutive data grants made while
//   a fetch was waiting. Without it, data priority is strict.
//
// Ports
//   clock, reset            system clock; synchronous active-high reset
//   if_req, if_addr         fetch request and byte address
//   if_rdata, if_ready      fetched word and one-cycle completion pulse
//   d_rd, d_wr, d_addr,     data load/store request (rd & wr = store)
//   d_wdata
//   d_rdata, d_ready        load data and one-cycle completion pulse
//   mem_req, mem_we,        single-port memory request
//   mem_addr, mem_wdata
//   mem_rdata, mem_ack      memory read data and completion
//   pipe_stall              combinational stall back to the pipeline
//   err                     sticky watchdog-timeout flag
module mem_port_arbiter #(
  parameter int unsigned MAX_WAIT     = 15,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ready,
  input  logic        d_rd,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ack,
  output logic        pipe_stall,
  output logic        err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DATA  = 2'd2
  } state_t;

  // wait_q only ever holds 0 .. MAX_WAIT-1
  localparam int unsigned WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_q;
  logic          mem_we_q;
  logic [15:0]   mem_addr_q;
  logic [15:0]   mem_wdata_q;
  logic [15:0]   if_rdata_q;
  logic [15:0]   d_rdata_q;
  logic          if_ready_q;
  logic          d_ready_q;
  logic          err_q;

  logic d_req;
  logic d_req_eff;
  logic f_req_eff;
  logic fair_force;
  logic grant_d;
  logic grant_f;
  logic wait_limit;

  // output-decode strobes
  logic mem_req_c;
  logic finish;
  logic ld_data;
  logic ld_fetch;
  logic fin_fetch;
  logic fin_data;

  // A port is masked in the cycle its own ready is high so the request that
  // just completed is not issued twice.
  assign d_req      = d_rd | d_wr;
  assign d_req_eff  = d_req & ~d_ready_q;
  assign f_req_eff  = if_req & ~if_ready_q;
  assign wait_limit = (wait_q == WW'(MAX_WAIT - 1));

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  logic [SW-1:0] starve_q;

  assign fair_force = (starve_q == SW'(STARVE_LIMIT));

  // Counts data grants taken while a fetch is outstanding (raw if_req, so a
  // fetch re-requesting in its own ready cycle still counts as waiting).
  always_ff @(posedge clock) begin
    if (reset) begin
      starve_q <= '0;
    end else if (ld_fetch) begin
      starve_q <= '0;
    end else if (ld_data && if_req && !fair_force) begin
      starve_q <= starve_q + SW'(1);
    end
  end
`else
  assign fair_force = 1'b0;
`endif

  // Fetch may only win against a raw (unmasked) data request when fairness
  // forces it; a data port sitting in its ready cycle still blocks fetch.
  assign grant_d = d_req_eff & ~(fair_force & f_req_eff);
  assign grant_f = f_req_eff & (~d_req | fair_force);

  // state register
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d = DATA;
        end else if (grant_f) begin
          state_d = FETCH;
        end
      end
      FETCH, DATA: begin
        if (mem_ack || wait_limit) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // output decode
  always_comb begin
    mem_req_c = 1'b0;
    ld_data   = 1'b0;
    ld_fetch  = 1'b0;
    fin_fetch = 1'b0;
    fin_data  = 1'b0;
    unique case (state_q)
      IDLE: begin
        ld_data  = grant_d;
        ld_fetch = grant_f;
      end
      FETCH: begin
        mem_req_c = 1'b1;
        fin_fetch = mem_ack | wait_limit;
      end
      DATA: begin
        mem_req_c = 1'b1;
        fin_data  = mem_ack | wait_limit;
      end
      default: begin
        mem_req_c = 1'b0;
      end
    endcase
  end

  assign finish = fin_fetch | fin_data;

  // request latch, wait watchdog, completion registers
  always_ff @(posedge clock) begin
    if (reset) begin
      wait_q      <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if_ready_q <= fin_fetch;
      d_ready_q  <= fin_data;

      if (mem_req_c && !finish) begin
        wait_q <= wait_q + WW'(1);
      end else begin
        wait_q <= '0;
      end

      if (ld_data) begin
        mem_we_q    <= d_wr;
        mem_addr_q  <= d_addr;
        mem_wdata_q <= d_wdata;
      end else if (ld_fetch) begin
        mem_we_q   <= 1'b0;
        mem_addr_q <= if_addr;
      end

      // an abort returns zero data (a NOP for the fetch side)
      if (fin_fetch) begin
        if_rdata_q <= mem_ack ? mem_rdata : '0;
      end
      if (fin_data && !mem_we_q) begin
        d_rdata_q <= mem_ack ? mem_rdata : '0;
      end

      if (finish && !mem_ack) begin
        err_q <= 1'b1;
      end
    end
  end

  assign mem_req    = mem_req_c;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign if_rdata   = if_rdata_q;
  assign if_ready   = if_ready_q;
  assign d_rdata    = d_rdata_q;
  assign d_ready    = d_ready_q;
  assign err        = err_q;
  assign pipe_stall = (if_req & ~if_ready_q) | (d_req & ~d_ready_q);

endmodule
